feature_lut_loader: RTL and testbench
=====================================

FEATURE_LUT_LOADER -- requirements
Module: feature_lut_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, LUT word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, LUT word width; a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 16384, number of words loaded per run; 1 <= DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle load request.
REQ-007 SHALL have port byte_valid  input  1  source byte valid.
REQ-008 SHALL have port byte_data  input  8  source byte.
REQ-009 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port mem_we  output  1  LUT RAM write strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_WIDTH  LUT RAM write address.
REQ-012 SHALL have port mem_wdata  output  DATA_WIDTH  LUT RAM write data.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  all DEPTH words written.
REQ-015 SHALL have port words_written  output  ADDR_WIDTH+1  count of words written this run.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DONE; all outputs registered.
REQ-017 IDLE: byte_ready=0, busy=0, done=0; start=1 -> LOAD next cycle, clearing byte index, write address, words_written.
REQ-018 LOAD: busy=1, byte_ready=1 except as in REQ-022; byte accepted only when byte_valid & byte_ready.
REQ-019 Bytes SHALL pack little-endian: first accepted byte of a word -> bits [7:0], k-th -> bits [8k+7:8k].
REQ-020 On acceptance of word's last byte (index DATA_WIDTH/8-1), the following cycle SHALL present mem_we=1 for exactly one cycle with mem_addr = current word address and mem_wdata = assembled word.
REQ-021 Address and words_written SHALL increment once per write; byte assembly of next word SHALL continue concurrently (no bubble; one byte per cycle sustained).
REQ-022 After last byte of word DEPTH-1 is accepted, byte_ready SHALL be 0 from the next cycle; FSM -> DONE in the cycle the final write is presented.
REQ-023 DONE: done=1, busy=0, byte_ready=0, held until start; start in DONE -> LOAD (done=0 next cycle, new run from address 0).
REQ-024 start in LOAD SHALL be ignored.
REQ-025 byte_valid=0 stalls shall preserve partial word and index indefinitely.
REQ-026 mem_we SHALL be 0 whenever not presenting a completed word; mem_addr/mem_wdata hold last written values otherwise.

Reset
REQ-027 rst=1 SHALL force IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, words_written=0, byte index=0.
REQ-028 Reset mid-LOAD SHALL discard any partial word; no write issued after rst sampled high.

Configuration
REQ-029 With FEATURE_LUT_LOADER_CHECKSUM_EN defined, SHALL add output lut_checksum (DATA_WIDTH): modulo-2^DATA_WIDTH sum of all words written this run, updated the cycle after each write, cleared on reset and on start-to-LOAD.
REQ-030 Without FEATURE_LUT_LOADER_CHECKSUM_EN, port lut_checksum and its adder SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold FSM state typedef (IDLE, LOAD, DONE) and BYTES_PER_WORD constant derivation.
REQ-032 Byte-to-word packing SHALL be sub-module feature_lut_word_packer (byte in, word + word_valid out); FSM, address counter, checksum in top.

Verification
REQ-033 DEPTH=4, DATA_WIDTH=32: start, stream bytes 00..0F back-to-back -> writes addr0=0x03020100, addr1=0x07060504, addr2=0x0B0A0908, addr3=0x0F0E0D0C on consecutive 4-cycle intervals; done=1, words_written=4.
REQ-034 Same with byte_valid toggling 1/0 every cycle -> identical write data/addresses, each mem_we one cycle, no byte lost or duplicated.
REQ-035 rst asserted after 6 bytes accepted -> one write (addr0) seen, then all outputs at reset values; new start + 16 bytes reloads from addr0.
REQ-036 start pulsed during LOAD after byte 5 -> ignored; run completes normally with 4 writes.
REQ-037 With FEATURE_LUT_LOADER_CHECKSUM_EN, REQ-033 stream -> lut_checksum = 0x24201C18 after final write; second run via start in DONE restarts sum from 0.
REQ-038 After DONE, byte_valid=1 held 10 cycles -> byte_ready=0, no mem_we, done stays 1.

Source files
------------

// File: rtl/feature_lut_loader_pkg.sv
// Shared types and helpers for the LUT loader: FSM state encoding and byte/word geometry.
package feature_lut_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } lut_state_e;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Keep the byte index at least one bit wide so 8-bit words still elaborate.
    function automatic int unsigned index_width(input int unsigned bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/feature_lut_word_packer.sv
// Little-endian byte-to-word packer: word/word_valid are combinational and flag the
// cycle in which the last byte of a word is accepted.
module feature_lut_word_packer
    import feature_lut_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [7:0]            byte_data,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int unsigned BPW   = bytes_per_word(DATA_WIDTH);
    localparam int unsigned IDX_W = index_width(BPW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [DATA_WIDTH-1:0] partial_q;
    logic [IDX_W-1:0]      idx_q;

    always_comb begin
        word = partial_q;
        for (int k = 0; k < BPW; k++) begin
            if (idx_q == IDX_W'(k)) begin
                word[8*k +: 8] = byte_data;
            end
        end
        word_valid = byte_en && (idx_q == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            partial_q <= '0;
            idx_q     <= '0;
        end else if (byte_en) begin
            if (idx_q == LAST_IDX) begin
                partial_q <= '0;
                idx_q     <= '0;
            end else begin
                partial_q <= word;
                idx_q     <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/feature_lut_loader.sv
// Streams bytes into LUT RAM words, one write per completed word, DEPTH words per run.
// Optional running word checksum output enabled by FEATURE_LUT_LOADER_CHECKSUM_EN.
module feature_lut_loader
    import feature_lut_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written
`ifdef FEATURE_LUT_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] lut_checksum
`endif
);

    localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    lut_state_e            state;
    logic                  accept;
    logic                  start_load;
    logic [DATA_WIDTH-1:0] pack_word;
    logic                  pack_valid;

    assign accept     = byte_valid && byte_ready;
    assign start_load = start && (state != LOAD);

    feature_lut_word_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_load),
        .byte_en   (accept),
        .byte_data (byte_data),
        .word      (pack_word),
        .word_valid(pack_valid)
    );

    // words_written doubles as the next write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            byte_ready    <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            mem_we <= 1'b0;
            if (pack_valid) begin
                mem_we        <= 1'b1;
                mem_addr      <= words_written[ADDR_WIDTH-1:0];
                mem_wdata     <= pack_word;
                words_written <= words_written + (ADDR_WIDTH + 1)'(1);
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= LOAD;
                        busy          <= 1'b1;
                        byte_ready    <= 1'b1;
                        done          <= 1'b0;
                        words_written <= '0;
                    end
                end
                LOAD: begin
                    if (pack_valid && (words_written == LAST_COUNT)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        byte_ready <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FEATURE_LUT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || start_load) begin
            lut_checksum <= '0;
        end else if (mem_we) begin
            lut_checksum <= lut_checksum + mem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_feature_lut_loader.sv
// Self-checking bench for feature_lut_loader (DEPTH=4, 32-bit words) with a byte-queue model.
module tb_feature_lut_loader;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   words_written;
`ifdef FEATURE_LUT_LOADER_CHECKSUM_EN
    logic [DW-1:0] lut_checksum;
`endif

    feature_lut_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .words_written(words_written)
`ifdef FEATURE_LUT_LOADER_CHECKSUM_EN
        ,
        .lut_checksum (lut_checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]    sent_q[$];
    logic [7:0]    acc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    logic          wr_done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
            wr_done_q.push_back(done);
        end
        if (byte_valid && byte_ready === 1'b1) acc_q.push_back(byte_data);
    end

    // Word i is bytes 4i..4i+3 of the offered-and-accepted stream, little-endian.
    function automatic logic [DW-1:0] model_word(input int i);
        logic [DW-1:0] w = '0;
        for (int b = 0; b < DW / 8; b++) w[8*b +: 8] = sent_q[(DW / 8) * i + b];
        return w;
    endfunction

    function automatic logic [DW-1:0] model_sum();
        logic [DW-1:0] s = '0;
        for (int i = 0; i < DEPTH; i++) s = s + model_word(i);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        sent_q.delete();
        acc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        wr_done_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // pat: 0 = always valid, 1 = toggle every cycle, 2 = random valid.
    task automatic send_bytes(input int n, input int pat, input bit seq);
        int         sent   = 0;
        int         cycles = 0;
        logic [7:0] cur;
        bit         v;
        bit         rdy;
        cur = seq ? 8'(sent) : 8'($urandom);
        while (sent < n && cycles < 200) begin
            case (pat)
                0:       v = 1'b1;
                1:       v = (cycles % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid = v;
            byte_data  = cur;
            rdy        = byte_ready;
            tick();
            cycles++;
            if (v && rdy) begin
                sent_q.push_back(cur);
                sent++;
                cur = seq ? 8'(sent) : 8'($urandom);
            end
        end
        byte_valid = 1'b0;
        n_checks++;
        if (sent !== n) begin
            n_fail++;
            $display("FAIL send_bytes: accepted %0d bytes, required %0d", sent, n);
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, k);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) tick();
        n_checks += 7;
        if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset byte_ready: %b required 0", byte_ready); end
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset mem_we: %b required 0", mem_we); end
        if (mem_addr !== '0) begin n_fail++; $display("FAIL reset mem_addr: %h required 0", mem_addr); end
        if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset mem_wdata: %h required 0", mem_wdata); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: %b required 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: %b required 0", done); end
        if (words_written !== '0) begin n_fail++; $display("FAIL reset words_written: %0d required 0", words_written); end
`ifdef FEATURE_LUT_LOADER_CHECKSUM_EN
        n_checks++;
        if (lut_checksum !== '0) begin n_fail++; $display("FAIL reset lut_checksum: %h required 0", lut_checksum); end
`endif
        rst = 1'b0;
        byte_valid = 1'b1;
        repeat (3) tick();
        byte_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy=%b byte_ready=%b accepted=%0d, required 0/0/0",
                     busy, byte_ready, acc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_entry: busy=%b ready=%b done=%b, required 1/1/0", busy, byte_ready, done);
        end
        send_bytes(16, 0, 1'b1);
        wait_done();
        n_checks++;
        if (wr_addr_q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL b2b write_count: %0d required %0d", wr_addr_q.size(), DEPTH);
        end
        n_checks++;
        if (wr_data_q.size() > 0 && wr_data_q[0] !== 32'h03020100) begin
            n_fail++;
            $display("FAIL b2b word0_literal: %h required 03020100", wr_data_q[0]);
        end
        for (int i = 0; i < wr_addr_q.size() && i < DEPTH; i++) begin
            n_checks += 2;
            if (wr_addr_q[i] !== AW'(i)) begin
                n_fail++;
                $display("FAIL b2b addr[%0d]: %0d required %0d", i, wr_addr_q[i], i);
            end
            if (wr_data_q[i] !== model_word(i)) begin
                n_fail++;
                $display("FAIL b2b data[%0d]: %h required %h", i, wr_data_q[i], model_word(i));
            end
            if (i > 0) begin
                n_checks++;
                if (wr_cyc_q[i] - wr_cyc_q[i-1] != 4) begin
                    n_fail++;
                    $display("FAIL b2b spacing[%0d]: %0d cycles required 4", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
                end
            end
        end
        n_checks++;
        if (wr_done_q.size() == DEPTH && wr_done_q[DEPTH-1] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b done_with_last_write: %b required 1", wr_done_q[DEPTH-1]);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || words_written !== 5'd4) begin
            n_fail++;
            $display("FAIL b2b final: done=%b busy=%b ready=%b words=%0d, required 1/0/0/4",
                     done, busy, byte_ready, words_written);
        end
`ifdef FEATURE_LUT_LOADER_CHECKSUM_EN
        n_checks++;
        if (lut_checksum !== 32'h24201C18) begin
            n_fail++;
            $display("FAIL b2b checksum: %h required 24201c18", lut_checksum);
        end
`endif
    endtask

    // Run started from DONE with stalled byte_valid and random data.
    task automatic test_stalls(input int pat);
        clear_logs();
        pulse_start();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall%0d restart: done=%b busy=%b, required 0/1", pat, done, busy);
        end
        send_bytes(16, pat, 1'b0);
        wait_done();
        n_checks++;
        if (wr_addr_q.size() != DEPTH || acc_q.size() != 16) begin
            n_fail++;
            $display("FAIL stall%0d counts: writes=%0d bytes=%0d, required %0d/16",
                     pat, wr_addr_q.size(), acc_q.size(), DEPTH);
        end
        for (int i = 0; i < acc_q.size() && i < sent_q.size(); i++) begin
            n_checks++;
            if (acc_q[i] !== sent_q[i]) begin
                n_fail++;
                $display("FAIL stall%0d byte[%0d]: %h required %h", pat, i, acc_q[i], sent_q[i]);
            end
        end
        for (int i = 0; i < wr_addr_q.size() && i < DEPTH; i++) begin
            n_checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== model_word(i)) begin
                n_fail++;
                $display("FAIL stall%0d write[%0d]: %0d:%h required %0d:%h",
                         pat, i, wr_addr_q[i], wr_data_q[i], i, model_word(i));
            end
        end
`ifdef FEATURE_LUT_LOADER_CHECKSUM_EN
        n_checks++;
        if (lut_checksum !== model_sum()) begin
            n_fail++;
            $display("FAIL stall%0d checksum: %h required %h", pat, lut_checksum, model_sum());
        end
`endif
    endtask

    task automatic test_reset_mid_load();
        clear_logs();
        pulse_start();
        send_bytes(6, 0, 1'b0);
        rst = 1'b1;
        tick();
        n_checks++;
        if (byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || words_written !== '0) begin
            n_fail++;
            $display("FAIL midrst outputs: ready=%b we=%b addr=%0d wdata=%h busy=%b done=%b words=%0d, required all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, busy, done, words_written);
        end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (wr_addr_q.size() != 1) begin
            n_fail++;
            $display("FAIL midrst write_count: %0d required 1", wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== '0 || wr_data_q[0] !== model_word(0)) begin
                n_fail++;
                $display("FAIL midrst write0: %0d:%h required 0:%h", wr_addr_q[0], wr_data_q[0], model_word(0));
            end
        end
        clear_logs();
        pulse_start();
        send_bytes(16, 2, 1'b0);
        wait_done();
        n_checks++;
        if (wr_addr_q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL midrst reload_count: %0d required %0d", wr_addr_q.size(), DEPTH);
        end
        for (int i = 0; i < wr_addr_q.size() && i < DEPTH; i++) begin
            n_checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== model_word(i)) begin
                n_fail++;
                $display("FAIL midrst reload[%0d]: %0d:%h required %0d:%h",
                         i, wr_addr_q[i], wr_data_q[i], i, model_word(i));
            end
        end
    endtask

    task automatic test_start_ignored();
        clear_logs();
        pulse_start();
        send_bytes(5, 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || words_written !== 5'd1) begin
            n_fail++;
            $display("FAIL ign_start state: busy=%b words=%0d, required 1/1", busy, words_written);
        end
        send_bytes(11, 0, 1'b0);
        wait_done();
        n_checks++;
        if (wr_addr_q.size() != DEPTH || words_written !== 5'd4) begin
            n_fail++;
            $display("FAIL ign_start counts: writes=%0d words=%0d, required %0d/4",
                     wr_addr_q.size(), words_written, DEPTH);
        end
        for (int i = 0; i < wr_addr_q.size() && i < DEPTH; i++) begin
            n_checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== model_word(i)) begin
                n_fail++;
                $display("FAIL ign_start write[%0d]: %0d:%h required %0d:%h",
                         i, wr_addr_q[i], wr_data_q[i], i, model_word(i));
            end
        end
    endtask

    task automatic test_done_hold();
        int n_wr = wr_addr_q.size();
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (byte_ready !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL done_hold cycle %0d: ready=%b done=%b busy=%b, required 0/1/0",
                         c, byte_ready, done, busy);
            end
        end
        byte_valid = 1'b0;
        tick();
        n_checks++;
        if (wr_addr_q.size() != n_wr || words_written !== 5'd4) begin
            n_fail++;
            $display("FAIL done_hold writes: %0d words=%0d, required %0d/4",
                     wr_addr_q.size(), words_written, n_wr);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_done_hold();
        test_stalls(1);
        test_stalls(2);
        test_start_ignored();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
